wheel_encoder_reader: RTL and testbench

Quadrature decoder for the drive-wheel encoders, closing the loop on the motor driver outputs. It samples the asynchronous A/B channels of one wheel encoder, tracks signed wheel position, and measures signed speed over a fixed window aligned to the 101-cycle motor PWM period. It flags illegal transitions for the steering controller. One instance is used per wheel.

---
 rtl/wheel_encoder_reader.sv | 177 +++++++++++++++++
 tb/tb_wheel_encoder_reader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wheel_encoder_reader.sv
// Quadrature decoder for one drive wheel: synchronizes the A/B channels, tracks signed
// position, and reports signed speed once per PWM-aligned window.
module wheel_encoder_reader #(
    parameter int CNT_W   = 16,
    parameter int SPEED_W = 8,
    parameter int WINDOW  = 101
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clear,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   position,
    output logic [SPEED_W-1:0] speed,
    output logic               speed_valid,
    output logic               dir,
    output logic               err
);

    localparam int                 WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [SPEED_W-1:0] SAT_MAX  = {1'b0, {(SPEED_W-1){1'b1}}};
    localparam logic [SPEED_W-1:0] SAT_MIN  = {1'b1, {(SPEED_W-1){1'b0}}};

    typedef enum logic [1:0] {
        PRIME_0,
        PRIME_1,
        PRIME_DONE
    } prime_e;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } step_e;

    logic               a_s1_q, a_s2_q;
    logic               b_s1_q, b_s2_q;
    logic [1:0]         cur;
    logic [1:0]         prev_q, prev_d;
    prime_e             prime_q, prime_d;
    logic               primed;
    step_e              step;

    logic [CNT_W-1:0]   position_q, position_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] acc_q, acc_d, acc_sum;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               speed_valid_q, speed_valid_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;

    function automatic logic [SPEED_W-1:0] sat_step(input logic [SPEED_W-1:0] a,
                                                   input step_e s);
        sat_step = a;
        if (s == STEP_FWD && a != SAT_MAX) begin
            sat_step = a + SPEED_W'(1);
        end else if (s == STEP_REV && a != SAT_MIN) begin
            sat_step = a - SPEED_W'(1);
        end
    endfunction

    assign cur    = {a_s2_q, b_s2_q};
    assign primed = (prime_q == PRIME_DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the synchronizer a chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_s1_q        <= 1'b0;
            a_s2_q        <= 1'b0;
            b_s1_q        <= 1'b0;
            b_s2_q        <= 1'b0;
            prev_q        <= 2'b00;
            prime_q       <= PRIME_0;
            position_q    <= '0;
            speed_q       <= '0;
            acc_q         <= '0;
            win_q         <= '0;
            speed_valid_q <= 1'b0;
            dir_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            a_s1_q        <= enc_a;
            a_s2_q        <= a_s1_q;
            b_s1_q        <= enc_b;
            b_s2_q        <= b_s1_q;
            prev_q        <= prev_d;
            prime_q       <= prime_d;
            position_q    <= position_d;
            speed_q       <= speed_d;
            acc_q         <= acc_d;
            win_q         <= win_d;
            speed_valid_q <= speed_valid_d;
            dir_q         <= dir_d;
            err_q         <= err_d;
        end
    end

    // Priming loads prev with the value cur takes next, so decoding starts from a settled pair.
    always_comb begin
        prime_d = prime_q;
        prev_d  = primed ? cur : {a_s1_q, b_s1_q};
        case (prime_q)
            PRIME_0: prime_d = PRIME_1;
            PRIME_1: prime_d = PRIME_DONE;
            default: prime_d = PRIME_DONE;
        endcase
    end

    always_comb begin
        step = STEP_NONE;
        if (primed) begin
            case ({prev_q, cur})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_FWD;
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_REV;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ILLEGAL;
                default:                                step = STEP_NONE;
            endcase
        end
    end

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        position_d    = position_q;
        dir_d         = dir_q;
        err_d         = err_q;
        acc_d         = acc_q;
        win_d         = win_q;
        speed_d       = speed_q;
        speed_valid_d = 1'b0;
        acc_sum       = sat_step(acc_q, step);

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (step)
            STEP_FWD: begin
                position_d = position_q + CNT_W'(1);
                dir_d      = 1'b1;
            end
            STEP_REV: begin
                position_d = position_q - CNT_W'(1);
                dir_d      = 1'b0;
            end
            STEP_ILLEGAL: err_d = 1'b1;
            default: ;
        endcase

        if (clear) begin
            position_d = '0;
        end

        // The step landing on the last window cycle is folded into the closing result.
        if (primed) begin
            if (win_q == WIN_LAST) begin
                speed_d       = acc_sum;
                speed_valid_d = 1'b1;
                acc_d         = '0;
                win_d         = '0;
            end else begin
                acc_d = acc_sum;
                win_d = win_q + WIN_W'(1);
            end
        end
    end

    assign position    = position_q;
    assign speed       = speed_q;
    assign speed_valid = speed_valid_q;
    assign dir         = dir_q;
    assign err         = err_q;

endmodule

// File: tb/tb_wheel_encoder_reader.sv
// Randomized and directed checks of wheel_encoder_reader against a transition-level
// reference model; a second instance with a narrow speed width exercises saturation.
module tb_wheel_encoder_reader;

    localparam int CNT_W    = 16;
    localparam int SPEED_W  = 8;
    localparam int SPEED_W2 = 6;
    localparam int WINDOW   = 101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enc_a = 1'b0, enc_b = 1'b0, clear = 1'b0, err_clr = 1'b0;
    logic [CNT_W-1:0]    position, position2;
    logic [SPEED_W-1:0]  speed;
    logic [SPEED_W2-1:0] speed2;
    logic speed_valid, dir, err, speed_valid2, dir2, err2;

    always #5 clk = ~clk;

    wheel_encoder_reader #(.CNT_W(CNT_W), .SPEED_W(SPEED_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .err_clr(err_clr),
        .position(position), .speed(speed), .speed_valid(speed_valid), .dir(dir), .err(err)
    );

    wheel_encoder_reader #(.CNT_W(CNT_W), .SPEED_W(SPEED_W2), .WINDOW(WINDOW)) dut2 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear), .err_clr(err_clr),
        .position(position2), .speed(speed2), .speed_valid(speed_valid2), .dir(dir2), .err(err2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pin samples per edge, decoded by quadrature phase difference.
    logic [1:0] enc;
    logic [1:0] p_hist [3];
    int m_edges, m_pos, m_win;
    int m_acc [2];
    int m_speed [2];
    bit m_sv, m_dir, m_err;

    function automatic int gray_idx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_code(input int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic m_reset();
        m_edges = 0; m_pos = 0; m_win = 0; m_sv = 0; m_dir = 0; m_err = 0;
        for (int w = 0; w < 2; w++) begin m_acc[w] = 0; m_speed[w] = 0; end
        for (int i = 0; i < 3; i++) p_hist[i] = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] pins, input bit clr, input bit eclr);
        int step, d, w_bits;
        bit illegal;
        step = 0; illegal = 0;
        m_edges++;
        // Pins sampled at edge k reach the decoder two edges later; edge 3 compares a settled pair.
        if (m_edges >= 4) begin
            d = (gray_idx(p_hist[1]) - gray_idx(p_hist[2]) + 4) % 4;
            if (d == 1) step = 1;
            else if (d == 3) step = -1;
            else if (d == 2) illegal = 1;
        end
        p_hist[2] = p_hist[1]; p_hist[1] = p_hist[0]; p_hist[0] = pins;
        m_sv = 0;
        if (m_edges >= 3) begin
            for (int w = 0; w < 2; w++) begin
                w_bits = (w == 0) ? SPEED_W : SPEED_W2;
                if (m_win == WINDOW - 1) begin
                    m_speed[w] = sat(m_acc[w] + step, w_bits);
                    m_acc[w] = 0;
                end else begin
                    m_acc[w] = sat(m_acc[w] + step, w_bits);
                end
            end
            if (m_win == WINDOW - 1) begin m_win = 0; m_sv = 1; end
            else m_win++;
        end
        m_pos = clr ? 0 : ((m_pos + step) & ((1 << CNT_W) - 1));
        if (step != 0) m_dir = (step > 0);
        if (illegal) m_err = 1;
        else if (eclr) m_err = 0;
    endtask

    task automatic cycle(input bit clr = 1'b0, input bit eclr = 1'b0);
        enc_a = enc[1]; enc_b = enc[0]; clear = clr; err_clr = eclr;
        @(posedge clk);
        model_edge(enc, clr, eclr);
        #1;
        clear = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_reset(input logic [1:0] pins);
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        enc = pins; enc_a = pins[1]; enc_b = pins[0];
        rst = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            cycle();
            got = speed_valid;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++; if (position !== '0) begin n_errors++; $display("FAIL rst_pos: got %h want 0", position); end
        n_checks++; if (speed !== '0) begin n_errors++; $display("FAIL rst_speed: got %h want 0", speed); end
        n_checks++; if (speed_valid !== 1'b0) begin n_errors++; $display("FAIL rst_sv: got %b want 0", speed_valid); end
        n_checks++; if (dir !== 1'b0) begin n_errors++; $display("FAIL rst_dir: got %b want 0", dir); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", err); end
    endtask

    task automatic test_forward();
        int want;
        apply_reset(2'b00);
        repeat (3) cycle();
        for (int s = 0; s < 4; s++) begin
            enc = gray_code(gray_idx(enc) + 1);
            for (int h = 0; h < 4; h++) begin
                cycle();
                want = (h >= 2) ? s + 1 : s;
                n_checks++;
                if (position !== CNT_W'(want)) begin
                    n_errors++; $display("FAIL fwd_latency s=%0d h=%0d: got %0d want %0d", s, h, position, want);
                end
            end
        end
        n_checks++; if (position !== 16'd4) begin n_errors++; $display("FAIL fwd_pos: got %0d want 4", position); end
        n_checks++; if (dir !== 1'b1) begin n_errors++; $display("FAIL fwd_dir: got %b want 1", dir); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL fwd_err: got %b want 0", err); end
    endtask

    task automatic test_reverse_wrap();
        apply_reset(2'b00);
        repeat (3) cycle();
        enc = 2'b10;
        repeat (3) cycle();
        n_checks++; if (position !== 16'hFFFF) begin n_errors++; $display("FAIL rev_pos1: got %h want ffff", position); end
        enc = 2'b11;
        repeat (4) cycle();
        n_checks++; if (position !== 16'hFFFE) begin n_errors++; $display("FAIL rev_pos2: got %h want fffe", position); end
        n_checks++; if (dir !== 1'b0) begin n_errors++; $display("FAIL rev_dir: got %b want 0", dir); end
    endtask

    task automatic test_illegal();
        apply_reset(2'b00);
        repeat (3) cycle();
        enc = 2'b11;
        repeat (3) cycle();
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL ill_err: got %b want 1", err); end
        n_checks++; if (position !== '0) begin n_errors++; $display("FAIL ill_pos: got %h want 0", position); end
        enc = 2'b00;
        cycle();
        cycle();
        cycle(1'b0, 1'b1);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL ill_set_wins: got %b want 1", err); end
        cycle(1'b0, 1'b1);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ill_err_clr: got %b want 0", err); end
        n_checks++; if (position !== '0) begin n_errors++; $display("FAIL ill_pos2: got %h want 0", position); end
    endtask

    task automatic test_speed_window();
        bit got;
        apply_reset(2'b00);
        wait_pulse(WINDOW + 10, got);
        n_checks++; if (!got) begin n_errors++; $display("FAIL win_first: got no pulse want pulse"); end
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) enc = gray_code(gray_idx(enc) + 1);
            cycle();
        end
        wait_pulse(WINDOW + 10, got);
        n_checks++; if (!got) begin n_errors++; $display("FAIL win_ten_pulse: got no pulse want pulse"); end
        n_checks++; if (speed_valid !== m_sv) begin n_errors++; $display("FAIL win_ten_timing: got %b want %b", speed_valid, m_sv); end
        n_checks++; if ($signed(speed) !== 10) begin n_errors++; $display("FAIL win_ten_speed: got %0d want 10", $signed(speed)); end
        cycle();
        n_checks++; if (speed_valid !== 1'b0) begin n_errors++; $display("FAIL win_pulse_width: got %b want 0", speed_valid); end
        n_checks++; if ($signed(speed) !== 10) begin n_errors++; $display("FAIL win_speed_hold: got %0d want 10", $signed(speed)); end
        wait_pulse(WINDOW + 10, got);
        n_checks++; if (!got || $signed(speed) !== 0) begin n_errors++; $display("FAIL win_idle: got pulse=%b speed=%0d want pulse=1 speed=0", got, $signed(speed)); end
        for (int i = 0; i < WINDOW && m_win != WINDOW - 3; i++) cycle();
        enc = gray_code(gray_idx(enc) + 1);
        cycle();
        wait_pulse(WINDOW + 10, got);
        n_checks++; if (!got || $signed(speed) !== 1) begin n_errors++; $display("FAIL win_boundary: got pulse=%b speed=%0d want pulse=1 speed=1", got, $signed(speed)); end
        wait_pulse(WINDOW + 10, got);
        n_checks++; if (!got || $signed(speed) !== 0) begin n_errors++; $display("FAIL win_after_boundary: got pulse=%b speed=%0d want pulse=1 speed=0", got, $signed(speed)); end
    endtask

    task automatic test_saturation_clear();
        bit got;
        int pulses, dstep, want1, want2;
        apply_reset(2'b00);
        for (int d = 0; d < 2; d++) begin
            dstep = (d == 0) ? 1 : -1;
            want1 = (d == 0) ? WINDOW : -WINDOW;
            want2 = (d == 0) ? 31 : -32;
            pulses = 0;
            wait_pulse(2 * WINDOW, got);
            n_checks++; if (!got) begin n_errors++; $display("FAIL sat_align d=%0d: got no pulse want pulse", d); end
            for (int i = 0; i < 2 * WINDOW + 4; i++) begin
                enc = gray_code(gray_idx(enc) + dstep);
                cycle();
                if (speed_valid) begin
                    pulses++;
                    n_checks++; if ($signed(speed) !== m_speed[0]) begin n_errors++; $display("FAIL sat_model8 d=%0d: got %0d want %0d", d, $signed(speed), m_speed[0]); end
                    n_checks++; if ($signed(speed2) !== m_speed[1]) begin n_errors++; $display("FAIL sat_model6 d=%0d: got %0d want %0d", d, $signed(speed2), m_speed[1]); end
                    if (pulses == 2) begin
                        n_checks++; if ($signed(speed) !== want1) begin n_errors++; $display("FAIL sat_full8 d=%0d: got %0d want %0d", d, $signed(speed), want1); end
                        n_checks++; if ($signed(speed2) !== want2) begin n_errors++; $display("FAIL sat_clip6 d=%0d: got %0d want %0d", d, $signed(speed2), want2); end
                    end
                end
            end
            n_checks++; if (pulses != 2) begin n_errors++; $display("FAIL sat_pulses d=%0d: got %0d want 2", d, pulses); end
        end
        wait_pulse(2 * WINDOW, got);
        enc = gray_code(gray_idx(enc) + 1);
        cycle();
        cycle();
        cycle(1'b1, 1'b0);
        n_checks++; if (position !== '0) begin n_errors++; $display("FAIL clr_pos: got %h want 0", position); end
        wait_pulse(WINDOW + 10, got);
        n_checks++; if (!got || $signed(speed) !== 1) begin n_errors++; $display("FAIL clr_acc: got pulse=%b speed=%0d want pulse=1 speed=1", got, $signed(speed)); end
    endtask

    task automatic test_reset_mid();
        bit got;
        int n;
        apply_reset(2'b00);
        repeat (3) cycle();
        for (int i = 0; i < 37; i++) begin
            enc = gray_code(gray_idx(enc) + 1);
            cycle();
        end
        repeat (3) cycle();
        n_checks++; if (position !== 16'd37) begin n_errors++; $display("FAIL mid_pre_pos: got %0d want 37", position); end
        #3 rst = 1'b1;
        m_reset();
        #1;
        n_checks++; if (position !== '0 || speed !== '0 || speed_valid !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
            n_errors++; $display("FAIL mid_async: got pos=%h spd=%h sv=%b dir=%b err=%b want all 0", position, speed, speed_valid, dir, err);
        end
        repeat (2) @(posedge clk);
        #1;
        enc = 2'b11; enc_a = 1'b1; enc_b = 1'b1;
        rst = 1'b0;
        n = 0; got = 1'b0;
        for (int i = 0; i < 3 * WINDOW && !got; i++) begin
            cycle();
            n++;
            got = speed_valid;
        end
        n_checks++; if (!got) begin n_errors++; $display("FAIL mid_pulse: got none want pulse"); end
        n_checks++; if (n != WINDOW + 2) begin n_errors++; $display("FAIL mid_pulse_edge: got %0d want %0d", n, WINDOW + 2); end
        n_checks++; if (position !== '0) begin n_errors++; $display("FAIL mid_prime_pos: got %h want 0", position); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL mid_prime_err: got %b want 0", err); end
        n_checks++; if (speed !== '0) begin n_errors++; $display("FAIL mid_prime_speed: got %h want 0", speed); end
    endtask

    task automatic test_random();
        int r;
        bit clr, eclr;
        apply_reset(2'($urandom_range(0, 3)));
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 92) enc = gray_code(gray_idx(enc) + 2);
            else if (r >= 70) enc = gray_code(gray_idx(enc) - 1);
            else if (r >= 45) enc = gray_code(gray_idx(enc) + 1);
            clr  = ($urandom_range(0, 39) == 0);
            eclr = ($urandom_range(0, 29) == 0);
            cycle(clr, eclr);
            n_checks++; if (position !== CNT_W'(m_pos)) begin n_errors++; $display("FAIL rnd_pos @%0d: got %h want %h", i, position, CNT_W'(m_pos)); end
            n_checks++; if (position2 !== CNT_W'(m_pos)) begin n_errors++; $display("FAIL rnd_pos2 @%0d: got %h want %h", i, position2, CNT_W'(m_pos)); end
            n_checks++; if (dir !== m_dir || dir2 !== m_dir) begin n_errors++; $display("FAIL rnd_dir @%0d: got %b/%b want %b", i, dir, dir2, m_dir); end
            n_checks++; if (err !== m_err || err2 !== m_err) begin n_errors++; $display("FAIL rnd_err @%0d: got %b/%b want %b", i, err, err2, m_err); end
            n_checks++; if (speed_valid !== m_sv || speed_valid2 !== m_sv) begin n_errors++; $display("FAIL rnd_sv @%0d: got %b/%b want %b", i, speed_valid, speed_valid2, m_sv); end
            n_checks++; if ($signed(speed) !== m_speed[0]) begin n_errors++; $display("FAIL rnd_speed @%0d: got %0d want %0d", i, $signed(speed), m_speed[0]); end
            n_checks++; if ($signed(speed2) !== m_speed[1]) begin n_errors++; $display("FAIL rnd_speed2 @%0d: got %0d want %0d", i, $signed(speed2), m_speed[1]); end
        end
    endtask

    initial begin
        enc = 2'b00;
        m_reset();
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_illegal();
        test_speed_window();
        test_saturation_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
